// File: rtl/closest_hit_tracker.sv
// Closest-hit tracker: folds a stream of quadratic-solver roots for one ray into
// the nearest qualifying root and its object tag, then holds it until accepted.
module closest_hit_tracker #(
  parameter int unsigned OBJ_W = 4,
  parameter logic [23:0] T_MIN = 24'h000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [23:0]      t,
  input  logic             t_ok,
  input  logic [OBJ_W-1:0] obj_idx,
  input  logic             last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_hit,
  output logic [23:0]      out_t,
  output logic [OBJ_W-1:0] out_idx,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned T_W   = 24;
  localparam int unsigned MAG_W = 23;
  // A zero root never qualifies, so the lower bound is at least one ulp.
  localparam logic [MAG_W-1:0] T_LO = (T_MIN[MAG_W-1:0] == '0) ? MAG_W'(1) : T_MIN[MAG_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_best_hit;
  logic [T_W-1:0]     r_best_t;
  logic [OBJ_W-1:0]   r_best_idx;
  logic               w_best_hit_nxt;
  logic [T_W-1:0]     w_best_t_nxt;
  logic [OBJ_W-1:0]   w_best_idx_nxt;

  logic               r_out_valid;
  logic               r_out_hit;
  logic [T_W-1:0]     r_out_t;
  logic [OBJ_W-1:0]   r_out_idx;
  logic               r_busy;
  logic               r_overflow;
  logic               w_out_hit_nxt;
  logic [T_W-1:0]     w_out_t_nxt;
  logic [OBJ_W-1:0]   w_out_idx_nxt;
  logic               w_overflow_nxt;

  logic               w_qual;
  logic               w_base_hit;
  logic [T_W-1:0]     w_base_t;
  logic [OBJ_W-1:0]   w_base_idx;
  logic               w_take;
  logic               w_fold_hit;
  logic [T_W-1:0]     w_fold_t;
  logic [OBJ_W-1:0]   w_fold_idx;

  assign out_valid = r_out_valid;
  assign out_hit   = r_out_hit;
  assign out_t     = r_out_t;
  assign out_idx   = r_out_idx;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

  // Slot qualification and fold against the running best (cleared by a same-cycle start).
  always_comb begin
    w_qual     = in_valid & t_ok & ~t[T_W-1] & (t[MAG_W-1:0] >= T_LO);
    w_base_hit = start ? 1'b0 : r_best_hit;
    w_base_t   = start ? '0   : r_best_t;
    w_base_idx = start ? '0   : r_best_idx;
    w_take     = w_qual & (~w_base_hit | (t[MAG_W-1:0] < w_base_t[MAG_W-1:0]));
    w_fold_hit = w_take | w_base_hit;
    w_fold_t   = w_take ? t       : w_base_t;
    w_fold_idx = w_take ? obj_idx : w_base_idx;
  end

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt    = r_state;
    w_best_hit_nxt = r_best_hit;
    w_best_t_nxt   = r_best_t;
    w_best_idx_nxt = r_best_idx;
    w_out_hit_nxt  = r_out_hit;
    w_out_t_nxt    = r_out_t;
    w_out_idx_nxt  = r_out_idx;
    w_overflow_nxt = r_overflow;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_best_hit_nxt = 1'b0;
          w_best_t_nxt   = '0;
          w_best_idx_nxt = '0;
          w_state_nxt    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_best_hit_nxt = w_fold_hit;
        w_best_t_nxt   = w_fold_t;
        w_best_idx_nxt = w_fold_idx;
        if (in_valid && last) begin
          w_out_hit_nxt = w_fold_hit;
          w_out_t_nxt   = w_fold_hit ? w_fold_t   : '0;
          w_out_idx_nxt = w_fold_hit ? w_fold_idx : '0;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        if (in_valid) begin
          w_overflow_nxt = 1'b1;
        end
        if (out_ready) begin
          if (start) begin
            w_best_hit_nxt = 1'b0;
            w_best_t_nxt   = '0;
            w_best_idx_nxt = '0;
            w_state_nxt    = S_ACCUM;
          end else begin
            w_state_nxt    = S_IDLE;
          end
        end else if (start) begin
          w_overflow_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, best-so-far and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_best_hit  <= 1'b0;
      r_best_t    <= '0;
      r_best_idx  <= '0;
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_t     <= '0;
      r_out_idx   <= '0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_best_hit  <= w_best_hit_nxt;
      r_best_t    <= w_best_t_nxt;
      r_best_idx  <= w_best_idx_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
      r_out_hit   <= w_out_hit_nxt;
      r_out_t     <= w_out_t_nxt;
      r_out_idx   <= w_out_idx_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_overflow  <= w_overflow_nxt;
    end
  end

endmodule

// File: tb/tb_closest_hit_tracker.sv
// Bench for closest_hit_tracker: directed table, hand-written corner sequences,
// and randomized rays checked against a min-search reference model.
module tb_closest_hit_tracker;

  localparam int unsigned OBJ_W = 4;
  localparam logic [23:0] TMIN  = 24'h200000;
  // fp24 constants: 7-bit exponent (bias 63), 16-bit mantissa.
  localparam logic [23:0] F1_0  = 24'h3F0000;
  localparam logic [23:0] F1_5  = 24'h3F8000;
  localparam logic [23:0] F2_0  = 24'h400000;
  localparam logic [23:0] F3_0  = 24'h408000;
  localparam logic [23:0] F4_0  = 24'h410000;
  localparam logic [23:0] F5_0  = 24'h414000;
  localparam logic [23:0] FN1_0 = 24'hBF0000;
  localparam logic [23:0] FSUB  = 24'h1F0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic [23:0]      t;
  logic             t_ok;
  logic [OBJ_W-1:0] obj_idx;
  logic             last;
  logic             out_ready;
  logic             out_valid;
  logic             out_hit;
  logic [23:0]      out_t;
  logic [OBJ_W-1:0] out_idx;
  logic             busy;
  logic             overflow;

  closest_hit_tracker #(.OBJ_W(OBJ_W), .T_MIN(TMIN)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .t(t), .t_ok(t_ok),
    .obj_idx(obj_idx), .last(last), .out_ready(out_ready), .out_valid(out_valid),
    .out_hit(out_hit), .out_t(out_t), .out_idx(out_idx), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int               n;
    logic [2:0][23:0] ts;
    logic [2:0]       oks;
    logic [2:0][3:0]  ixs;
    int               stall;
    logic             eh;
    logic [23:0]      et;
    logic [3:0]       ei;
  } vec_t;

  vec_t tab[6];

  logic [23:0] mq_t[$];
  logic        mq_ok[$];
  logic [3:0]  mq_i[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    start = 1'b0; in_valid = 1'b0; t = '0; t_ok = 1'b0; obj_idx = '0; last = 1'b0;
  endtask

  task automatic slot(input logic st, input logic [23:0] tv, input logic ok,
                      input logic [3:0] ix, input logic lst);
    start = st; in_valid = 1'b1; t = tv; t_ok = ok; obj_idx = ix; last = lst;
    tick();
    clr_in();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic eh, input logic [23:0] et,
                              input logic [3:0] ei);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_hit"}, out_hit, eh);
    chk({name, "_t"}, out_t, et);
    chk({name, "_idx"}, out_idx, ei);
  endtask

  function automatic vec_t mk(int n, logic [23:0] t0, logic o0, logic [3:0] i0,
                              logic [23:0] t1, logic o1, logic [3:0] i1,
                              logic [23:0] t2, logic o2, logic [3:0] i2,
                              int stall, logic eh, logic [23:0] et, logic [3:0] ei);
    vec_t v;
    v.n = n;
    v.ts[0] = t0; v.oks[0] = o0; v.ixs[0] = i0;
    v.ts[1] = t1; v.oks[1] = o1; v.ixs[1] = i1;
    v.ts[2] = t2; v.oks[2] = o2; v.ixs[2] = i2;
    v.stall = stall; v.eh = eh; v.et = et; v.ei = ei;
    return v;
  endfunction

  function automatic logic qualifies(logic [23:0] tv, logic ok);
    return ok && !tv[23] && (tv[22:0] >= TMIN[22:0]) && (tv[22:0] != 23'd0);
  endfunction

  // Reference: smallest qualifying magnitude, first occurrence wins ties.
  task automatic ref_best(output logic h, output logic [23:0] bt, output logic [3:0] bi);
    logic [22:0] mn;
    h = 1'b0; bt = '0; bi = '0; mn = '1;
    foreach (mq_t[k]) if (qualifies(mq_t[k], mq_ok[k])) begin
      h = 1'b1;
      if (mq_t[k][22:0] < mn) mn = mq_t[k][22:0];
    end
    if (h) begin
      for (int k = mq_t.size() - 1; k >= 0; k--) begin
        if (qualifies(mq_t[k], mq_ok[k]) && mq_t[k][22:0] == mn) begin
          bt = mq_t[k]; bi = mq_i[k];
        end
      end
    end
  endtask

  function automatic logic [23:0] rand_t();
    case ($urandom_range(0, 5))
      0: return 24'($urandom);
      1: return 24'(TMIN - 24'd1 + 24'($urandom_range(0, 2)));
      2: return 24'd0;
      3: return (mq_t.size() > 0) ? mq_t[$urandom_range(0, mq_t.size() - 1)] : F2_0;
      4: return {1'b0, 23'($urandom_range(0, 8))};
      default: return {1'b0, 23'($urandom)};
    endcase
  endfunction

  initial begin
    logic        eh;
    logic [23:0] et;
    logic [3:0]  ei;
    logic        exp_ovf;
    logic        started;

    tab[0] = mk(3, F3_0, 1, 2, F1_5, 1, 5, F2_0, 1, 7, 0, 1, F1_5, 5);
    tab[1] = mk(3, F3_0, 0, 2, FN1_0, 1, 3, FSUB, 1, 4, 0, 0, 24'h0, 0);
    tab[2] = mk(2, F2_0, 1, 1, F2_0, 1, 3, 24'h0, 0, 0, 5, 1, F2_0, 1);
    tab[3] = mk(2, 24'h0, 1, 1, TMIN, 1, 6, 24'h0, 0, 0, 0, 1, TMIN, 6);
    tab[4] = mk(3, F4_0, 1, 0, F1_0, 0, 8, F3_0, 1, 9, 1, 1, F3_0, 9);
    tab[5] = mk(1, F1_0, 1, 15, 24'h0, 0, 0, 24'h0, 0, 0, 2, 1, F1_0, 15);

    clr_in();
    out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_hit", out_hit, 0);
    chk("rst_t", out_t, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);

    // Slots without start in IDLE are ignored.
    slot(0, F1_0, 1, 1, 1);
    chk("idle_ign_busy", busy, 0);
    chk("idle_ign_valid", out_valid, 0);

    foreach (tab[i]) begin
      pulse_start();
      chk("tab_busy", busy, 1);
      for (int k = 0; k < tab[i].n; k++)
        slot(0, tab[i].ts[k], tab[i].oks[k], tab[i].ixs[k], (k == tab[i].n - 1));
      check_result("tab", tab[i].eh, tab[i].et, tab[i].ei);
      for (int s = 0; s < tab[i].stall; s++) begin
        tick();
        check_result("tab_hold", tab[i].eh, tab[i].et, tab[i].ei);
      end
      accept();
      chk("tab_idle_valid", out_valid, 0);
      chk("tab_idle_busy", busy, 0);
    end
    chk("tab_ovf", overflow, 0);

    // Start in ACCUM abandons the ray; the same-cycle slot joins the new one.
    pulse_start();
    slot(0, F1_0, 1, 1, 0);
    slot(1, F3_0, 1, 4, 0);
    slot(0, F4_0, 1, 5, 1);
    check_result("restart", 1, F3_0, 4);
    accept();

    // Back-to-back rays: start together with accept.
    pulse_start();
    slot(0, F1_0, 1, 3, 1);
    check_result("b2b_first", 1, F1_0, 3);
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_valid", out_valid, 0);
    slot(0, F4_0, 1, 0, 1);
    check_result("b2b_second", 1, F4_0, 0);
    accept();
    chk("b2b_ovf", overflow, 0);

    // Overflow: slot and unaccepted start in DONE are dropped.
    pulse_start();
    slot(0, F2_0, 1, 2, 1);
    slot(0, F1_0, 1, 7, 1);
    chk("ovf_set", overflow, 1);
    check_result("ovf_hold", 1, F2_0, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_result("ovf_start_hold", 1, F2_0, 2);
    accept();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_idle", busy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Mid-ray reset.
    pulse_start();
    slot(0, F1_0, 1, 1, 0);
    slot(0, F1_5, 1, 2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    pulse_start();
    slot(0, F5_0, 1, 9, 1);
    check_result("midrst", 1, F5_0, 9);
    accept();

    // Randomized rays against the reference model.
    exp_ovf = 1'b0;
    started = 1'b0;
    for (int r = 0; r < 80; r++) begin
      logic [23:0] tv;
      logic        ok;
      logic [3:0]  ix;
      logic        st;
      int          n;
      if (!started) pulse_start();
      mq_t.delete(); mq_ok.delete(); mq_i.delete();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        st = (k > 0) && ($urandom_range(0, 7) == 0);
        if (st) begin
          mq_t.delete(); mq_ok.delete(); mq_i.delete();
        end
        tv = rand_t();
        ok = ($urandom_range(0, 3) != 0);
        ix = 4'($urandom);
        mq_t.push_back(tv); mq_ok.push_back(ok); mq_i.push_back(ix);
        slot(st, tv, ok, ix, (k == n - 1));
      end
      ref_best(eh, et, ei);
      check_result("rand", eh, et, ei);
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
        case ($urandom_range(0, 3))
          0: begin
            slot(0, rand_t(), 1, 4'($urandom), $urandom_range(0, 1) == 1);
            exp_ovf = 1'b1;
          end
          1: begin
            start = 1'b1;
            tick();
            start = 1'b0;
            exp_ovf = 1'b1;
          end
          default: tick();
        endcase
        check_result("rand_hold", eh, et, ei);
      end
      started = ($urandom_range(0, 3) == 0);
      out_ready = 1'b1; start = started;
      tick();
      out_ready = 1'b0; start = 1'b0;
      chk("rand_busy", busy, started);
      chk("rand_ovf", overflow, exp_ovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
